ld_align_unit: RTL and testbench
================================

Name: ld_align_unit

Overview:
Load-path stage that sits directly upstream of the load-select (byte/half/word extract) stage.
- Accepts load requests from the MEM stage and issues word reads to synchronous data memory.
- Tracks request metadata across the memory read latency.
- Right-aligns the returned word by the byte offset, flags misaligned or unsupported accesses, and buffers results in an in-order response FIFO with valid/ready backpressure.
- Its outputs resp_data/resp_sel feed the load-select stage's din/sel directly.

Parameters:
DWIDTH, 32, data word width (only 32 supported)
AWIDTH, 14, byte-address width of req_addr
MEM_LATENCY, 1, cycles from mem_en to valid mem_dout (legal: 1 or 2)
RESP_DEPTH, 4, response FIFO entries (must be >= MEM_LATENCY+1; power of 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  load request present
req_ready  output  1  unit can accept request this cycle
req_addr  input  AWIDTH  byte address
req_sel  input  3  0=byte, 1=half, 2=word, 3..7 unsupported
mem_en  output  1  read enable to data memory
mem_addr  output  AWIDTH-2  word address = req_addr[AWIDTH-1:2]
mem_dout  input  DWIDTH  read data, valid MEM_LATENCY cycles after mem_en
resp_valid  output  1  response at FIFO head
resp_ready  input  1  consumer takes response
resp_data  output  DWIDTH  aligned word (to load-select din)
resp_sel  output  3  req_sel passed through (to load-select sel)
resp_misaligned  output  1  access was misaligned

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst. While rst=1:
  - req_ready=0, mem_en=0, resp_valid=0, resp_data=0, resp_sel=0, resp_misaligned=0.
  - Clears FIFO pointers, count and all latency-pipe valid bits.
  - Reads in flight at reset are discarded; mem_dout returning afterwards is ignored.
- Accept: a request is accepted when req_valid && req_ready.
  - req_ready = !rst && (inflight + count - pop) < RESP_DEPTH, where pop = resp_valid && resp_ready.
  - req_ready is therefore combinationally dependent on resp_ready.
- Classification at accept:
  - misaligned = (sel==1 && addr[0]) || (sel==2 && addr[1:0]!=0).
  - unsupported = sel > 2.
- Memory issue:
  - mem_en = accept && !misaligned && !unsupported, combinational in the accept cycle.
  - mem_addr is driven from req_addr every cycle.
- Latency pipe: every accepted request, including misaligned and unsupported ones, pushes {valid, offset=addr[1:0], sel, misaligned, unsupported} into a MEM_LATENCY-deep shift pipe. This preserves order.
- FIFO push: when the pipe tail is valid (the cycle mem_dout is valid for it), one entry is pushed.
  - data = mem_dout >> (8*offset), zero-filled from the top, for normal entries.
  - data = 0 for misaligned or unsupported entries.
  - sel passes through; misaligned is recorded.
- Latency: accept in cycle N gives resp_valid in cycle N+MEM_LATENCY+1 (registered FIFO output, with empty FIFO and resp_ready=1).
- FIFO:
  - resp_valid = count!=0; resp_* show the head entry.
  - Simultaneous push and pop leaves count unchanged. Push while full cannot occur (credit rule).
  - Pointers wrap modulo RESP_DEPTH.
- Throughput: with resp_ready held at 1, one request is accepted and one response is delivered per cycle with no bubbles.
- Backpressure: resp_valid/resp_* hold stable while resp_valid && !resp_ready.

Test Plan:
- MEM_LATENCY=1, mem word1=0xabcdef12; req addr=0x6 sel=1 accepted cycle N -> mem_en=1 and mem_addr=1 in cycle N; resp_valid in N+2 with resp_data=0x0000abcd, resp_sel=1, resp_misaligned=0.
- Byte loads at addr 0x4..0x7 sel=0 on the same word, streamed -> resp_data 0xabcdef12, 0x00abcdef, 0x0000abcd, 0x000000ab on consecutive cycles, no bubbles.
- Word load addr 0x5 sel=2 -> mem_en=0 on accept, resp_data=0, resp_misaligned=1; sel=3 at addr 0x4 -> mem_en=0, resp_data=0, resp_misaligned=0, resp_sel=3.
- resp_ready=0, RESP_DEPTH=4, six back-to-back requests -> exactly 4 accepted, then req_ready=0 with head stable. Raising resp_ready -> responses drain in order; the remaining 2 are accepted as credits free.
- MEM_LATENCY=2, 8 streamed word loads from addresses 0x0..0x1C with resp_ready=1 -> one accept per cycle, first resp_valid 3 cycles after first accept, data in order.
- Assert rst for 1 cycle with 2 reads in flight and 1 FIFO entry -> next cycle resp_valid=0 and req_ready=1. No stale response appears even though mem_dout keeps toggling; a new request completes normally.

Source files
------------

// File: rtl/ld_align_unit.sv
// ld_align_unit: load-path stage ahead of load-select.
// Issues word reads for load requests, carries request metadata across the
// memory read latency, right-aligns the returned word by the byte offset and
// queues results in an in-order response FIFO with valid/ready handshakes.
module ld_align_unit #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 14,
    parameter int MEM_LATENCY = 1,
    parameter int RESP_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [2:0]        req_sel,
    output logic              mem_en,
    output logic [AWIDTH-3:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_data,
    output logic [2:0]        resp_sel,
    output logic              resp_misaligned
);

    localparam int PW = $clog2(RESP_DEPTH);
    // Occupancy width: must hold in-flight reads plus every FIFO entry.
    localparam int OW = $clog2(RESP_DEPTH + MEM_LATENCY + 1) + 1;

    // Shift the returned word right by whole bytes; upper bytes fill with zero.
    function automatic logic [DWIDTH-1:0] align_word(input logic [DWIDTH-1:0] word,
                                                     input logic [1:0]        offset);
        return word >> {offset, 3'b000};
    endfunction

    // Halfwords need even addresses, words need 4-byte aligned addresses.
    function automatic logic is_misaligned(input logic [2:0] sel,
                                           input logic [1:0] offset);
        return (sel == 3'd1 && offset[0]) || (sel == 3'd2 && offset != 2'b00);
    endfunction

    logic              req_mis;
    logic              req_uns;
    logic              accept;
    logic              push;
    logic              pop;
    logic [OW-1:0]     inflight;
    logic [OW-1:0]     occupancy;
    logic [DWIDTH-1:0] push_data;

    // Latency pipe: one slot per cycle of memory latency, tail lines up with mem_dout.
    logic       vld_pipe [MEM_LATENCY];
    logic [1:0] off_pipe [MEM_LATENCY];
    logic [2:0] sel_pipe [MEM_LATENCY];
    logic       mis_pipe [MEM_LATENCY];
    logic       uns_pipe [MEM_LATENCY];

    // Response FIFO storage and control.
    logic [DWIDTH-1:0] data_mem [RESP_DEPTH];
    logic [2:0]        sel_mem  [RESP_DEPTH];
    logic              mis_mem  [RESP_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    assign req_mis  = is_misaligned(req_sel, req_addr[1:0]);
    assign req_uns  = req_sel > 3'd2;
    assign accept   = req_valid && req_ready;
    assign mem_en   = accept && !req_mis && !req_uns;
    assign mem_addr = req_addr[AWIDTH-1:2];

    assign push = vld_pipe[MEM_LATENCY-1];
    assign pop  = resp_valid && resp_ready;

    // Count reads still travelling through the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + OW'(vld_pipe[i]);
        end
    end

    // Credit check: every accepted request owns a FIFO slot until popped, so the
    // FIFO can never overflow. A pop this cycle frees its slot immediately.
    assign occupancy = inflight + OW'(count) - OW'(pop);
    assign req_ready = !rst && (occupancy < OW'(RESP_DEPTH));

    // Advance the valid bits of the latency pipe; reset drops reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                vld_pipe[i] <= 1'b0;
            end
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // Advance request metadata alongside the valid bits.
    always_ff @(posedge clk) begin
        off_pipe[0] <= req_addr[1:0];
        sel_pipe[0] <= req_sel;
        mis_pipe[0] <= req_mis;
        uns_pipe[0] <= req_uns;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            off_pipe[i] <= off_pipe[i-1];
            sel_pipe[i] <= sel_pipe[i-1];
            mis_pipe[i] <= mis_pipe[i-1];
            uns_pipe[i] <= uns_pipe[i-1];
        end
    end

    // Rejected accesses never read memory, so they return zero instead of mem_dout.
    assign push_data = (mis_pipe[MEM_LATENCY-1] || uns_pipe[MEM_LATENCY-1])
                       ? '0
                       : align_word(mem_dout, off_pipe[MEM_LATENCY-1]);

    // Write the aligned result into the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            sel_mem[wr_ptr]  <= sel_pipe[MEM_LATENCY-1];
            mis_mem[wr_ptr]  <= mis_pipe[MEM_LATENCY-1];
        end
    end

    // FIFO pointers and count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head of the FIFO drives the load-select inputs; forced quiet during reset.
    assign resp_valid      = !rst && (count != '0);
    assign resp_data       = rst ? '0 : data_mem[rd_ptr];
    assign resp_sel        = rst ? 3'd0 : sel_mem[rd_ptr];
    assign resp_misaligned = rst ? 1'b0 : mis_mem[rd_ptr];

endmodule

// File: tb/tb_ld_align_unit.sv
// Testbench for ld_align_unit: one instance with a 1-cycle memory, one with a
// 2-cycle memory, exercised in turn against a transaction-level reference.
module tb_ld_align_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [13:0] req_addr_0, req_addr_1;
    logic [2:0]  req_sel_0, req_sel_1;
    logic        mem_en_0, mem_en_1;
    logic [11:0] mem_addr_0, mem_addr_1;
    logic [31:0] mem_dout_0, mem_dout_1;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0, resp_ready_1;
    logic [31:0] resp_data_0, resp_data_1;
    logic [2:0]  resp_sel_0, resp_sel_1;
    logic        resp_mis_0, resp_mis_1;

    ld_align_unit #(.DWIDTH(32), .AWIDTH(14), .MEM_LATENCY(1), .RESP_DEPTH(4)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_0), .req_ready(req_ready_0),
        .req_addr(req_addr_0), .req_sel(req_sel_0),
        .mem_en(mem_en_0), .mem_addr(mem_addr_0), .mem_dout(mem_dout_0),
        .resp_valid(resp_valid_0), .resp_ready(resp_ready_0),
        .resp_data(resp_data_0), .resp_sel(resp_sel_0), .resp_misaligned(resp_mis_0)
    );

    ld_align_unit #(.DWIDTH(32), .AWIDTH(14), .MEM_LATENCY(2), .RESP_DEPTH(4)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_addr(req_addr_1), .req_sel(req_sel_1),
        .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_dout(mem_dout_1),
        .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
        .resp_data(resp_data_1), .resp_sel(resp_sel_1), .resp_misaligned(resp_mis_1)
    );

    // Synchronous memories; the read port shows random junk when not enabled.
    logic [31:0] mem_img [16];
    logic [31:0] m0_q, m1_q, m1_qq;
    always @(posedge clk) begin
        m0_q  <= mem_en_0 ? mem_img[mem_addr_0[3:0]] : $urandom();
        m1_q  <= mem_en_1 ? mem_img[mem_addr_1[3:0]] : $urandom();
        m1_qq <= m1_q;
    end
    assign mem_dout_0 = m0_q;
    assign mem_dout_1 = m1_qq;

    // Reference: queue of outstanding responses with the cycle each becomes visible.
    typedef struct {
        logic [31:0] data;
        logic [2:0]  sel;
        logic        mis;
        int          rdy;
    } exp_t;
    exp_t q[$];

    int cur   = 0;
    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, cur, cyc, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [13:0] a, input logic [2:0] s,
                        input logic rr, input logic r, output logic acc);
        logic        o_rdy, o_en, o_rv, o_mis;
        logic [11:0] o_ma;
        logic [31:0] o_d;
        logic [2:0]  o_s;
        logic        e_rv, e_pop, e_rdy, mis, uns, e_acc;
        int          lat;
        exp_t        e;
        @(negedge clk);
        rst          = r;
        req_valid_0  = (cur == 0) && v;
        req_valid_1  = (cur == 1) && v;
        req_addr_0   = a;
        req_addr_1   = a;
        req_sel_0    = s;
        req_sel_1    = s;
        resp_ready_0 = (cur == 0) ? rr : 1'b1;
        resp_ready_1 = (cur == 1) ? rr : 1'b1;
        #1;
        if (cur == 0) begin
            o_rdy = req_ready_0; o_en = mem_en_0; o_ma = mem_addr_0; o_rv = resp_valid_0;
            o_d = resp_data_0; o_s = resp_sel_0; o_mis = resp_mis_0;
        end else begin
            o_rdy = req_ready_1; o_en = mem_en_1; o_ma = mem_addr_1; o_rv = resp_valid_1;
            o_d = resp_data_1; o_s = resp_sel_1; o_mis = resp_mis_1;
        end
        lat  = (cur == 0) ? 1 : 2;
        e_rv = 1'b0;
        if (!r && q.size() > 0) begin
            if (q[0].rdy <= cyc) e_rv = 1'b1;
        end
        e_pop = e_rv && rr;
        e_rdy = !r && ((q.size() - int'(e_pop)) < 4);
        mis   = (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
        uns   = s > 3'd2;
        e_acc = v && e_rdy;

        chk("req_ready", 32'(o_rdy), 32'(e_rdy));
        chk("mem_en", 32'(o_en), 32'(e_acc && !mis && !uns));
        chk("mem_addr", 32'(o_ma), 32'(a >> 2));
        chk("resp_valid", 32'(o_rv), 32'(e_rv));
        if (r) begin
            chk("rst_resp_data", o_d, 32'h0);
            chk("rst_resp_sel", 32'(o_s), 32'h0);
            chk("rst_resp_mis", 32'(o_mis), 32'h0);
        end else if (e_rv) begin
            chk("resp_data", o_d, q[0].data);
            chk("resp_sel", 32'(o_s), 32'(q[0].sel));
            chk("resp_mis", 32'(o_mis), 32'(q[0].mis));
        end

        if (r) begin
            q.delete();
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_acc) begin
                e.data = (mis || uns) ? 32'h0 : (mem_img[a[5:2]] >> (8 * int'(a[1:0])));
                e.sel  = s;
                e.mis  = mis;
                e.rdy  = cyc + lat + 1;
                q.push_back(e);
            end
        end
        acc = e_acc;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 14'h0, 3'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic rand_phase(input int n);
        logic        acc;
        logic [13:0] a;
        logic [2:0]  s;
        for (int k = 0; k < n; k++) begin
            a = 14'($urandom());
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            step(1'($urandom_range(0, 1)), a, s, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0), acc);
        end
    endtask

    initial begin
        logic acc;
        int   i;
        rst = 1'b1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_addr_0 = '0; req_addr_1 = '0;
        req_sel_0 = '0; req_sel_1 = '0;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        for (int k = 0; k < 16; k++) mem_img[k] = $urandom();
        mem_img[1] = 32'habcdef12;

        // Reset with a request pending: nothing may be accepted or shown.
        step(1'b1, 14'h6, 3'd1, 1'b1, 1'b1, acc);
        step(1'b1, 14'h6, 3'd1, 1'b1, 1'b1, acc);
        idle(1);

        // Halfword at 0x6, then streamed byte loads across word 1.
        step(1'b1, 14'h6, 3'd1, 1'b1, 1'b0, acc);
        idle(3);
        for (int k = 4; k < 8; k++) step(1'b1, 14'(k), 3'd0, 1'b1, 1'b0, acc);
        idle(3);

        // Misaligned word and unsupported sel.
        step(1'b1, 14'h5, 3'd2, 1'b1, 1'b0, acc);
        step(1'b1, 14'h4, 3'd3, 1'b1, 1'b0, acc);
        idle(3);

        // Backpressure: six requests against a stalled consumer, then release.
        i = 0;
        for (int k = 0; k < 24; k++) begin
            if (i < 6) begin
                step(1'b1, 14'(i * 4), 3'd2, (k >= 8), 1'b0, acc);
                if (acc) i++;
            end else begin
                step(1'b0, 14'h0, 3'd0, 1'b1, 1'b0, acc);
            end
        end

        rand_phase(300);
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
        idle(2);

        // Two-cycle memory: streamed aligned words 0x0..0x1C.
        cur = 1;
        idle(2);
        for (int k = 0; k < 8; k++) step(1'b1, 14'(k * 4), 3'd2, 1'b1, 1'b0, acc);
        idle(5);

        // Reset with one FIFO entry and two reads in flight.
        step(1'b1, 14'h0, 3'd2, 1'b0, 1'b0, acc);
        step(1'b1, 14'h4, 3'd2, 1'b0, 1'b0, acc);
        step(1'b1, 14'h8, 3'd2, 1'b0, 1'b0, acc);
        step(1'b0, 14'h0, 3'd0, 1'b0, 1'b1, acc);
        idle(4);
        step(1'b1, 14'h6, 3'd1, 1'b1, 1'b0, acc);
        idle(4);

        rand_phase(300);
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
